approx_mult_err_acc: RTL

Error-metrics accumulator downstream of the 8x8 signed approximate multipliers. It accepts a stream of (x, y, approximate product) samples. For each sample it recomputes the exact product and accumulates per-run error statistics: error count, sum of absolute error, maximum absolute error and, optionally, the signed error sum. A run is a fixed number of samples. Results are held for readout until the next start.

---
 rtl/approx_mult_err_acc.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/approx_mult_err_acc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | approx_mult_err_acc: per-run error statistics for 8x8 approx multipliers |
// | Optional signed error sum built when ERR_SIGNED_SUM_EN is defined.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module approx_mult_err_acc #(
  parameter int N_SAMPLES = 256,
  parameter int ACC_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        x,
  input  logic [7:0]        y,
  input  logic [15:0]       prod_approx,
  output logic              busy,
  output logic              done,
  output logic [15:0]       sample_count,
  output logic [15:0]       err_count,
  output logic [ACC_W-1:0]  sum_abs_err,
  output logic [16:0]       max_abs_err,
  output logic              sum_overflow,
  output logic [ACC_W-1:0]  sum_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [16:0] N_LIM = 17'(N_SAMPLES);

  state_t             state_q, state_d;
  logic               s1_valid_q, s1_valid_d;
  logic [16:0]        s1_approx_q, s1_approx_d;
  logic [15:0]        s1_exact_q, s1_exact_d;
  logic               s2_valid_q, s2_valid_d;
  logic [16:0]        s2_err_q, s2_err_d;
  logic [16:0]        s2_abs_q, s2_abs_d;
  logic [15:0]        sample_count_q, sample_count_d;
  logic [15:0]        err_count_q, err_count_d;
  logic [ACC_W-1:0]   sum_abs_q, sum_abs_d;
  logic [16:0]        max_abs_q, max_abs_d;
  logic               ovf_q, ovf_d;

  logic               clear;
  logic               accept;
  logic               last_accept;
  logic signed [15:0] exact_w;
  logic [16:0]        e_w;
  logic [16:0]        abs_w;
  logic [ACC_W:0]     sum_abs_ext;

  assign in_ready    = (state_q == RUN) && ({1'b0, sample_count_q} < N_LIM);
  assign accept      = in_valid && in_ready;
  assign last_accept = accept && (({1'b0, sample_count_q} + 17'd1) == N_LIM);

  assign exact_w = $signed(x) * $signed(y);
  assign e_w     = s1_approx_q - {s1_exact_q[15], s1_exact_q};
  assign abs_w   = e_w[16] ? (17'd0 - e_w) : e_w;

  assign sum_abs_ext = {1'b0, sum_abs_q} + {{(ACC_W-16){1'b0}}, s2_abs_q};

  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          clear   = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (last_accept) state_d = DRAIN;
      end
      DRAIN: begin
        // Wait until the last sample has landed in the accumulators.
        if (!s1_valid_q && !s2_valid_q) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s1_valid_d  = accept;
    s1_approx_d = s1_approx_q;
    s1_exact_d  = s1_exact_q;
    if (accept) begin
      s1_approx_d = {prod_approx[15], prod_approx};
      s1_exact_d  = exact_w;
    end
    s2_valid_d = s1_valid_q;
    s2_err_d   = s2_err_q;
    s2_abs_d   = s2_abs_q;
    if (s1_valid_q) begin
      s2_err_d = e_w;
      s2_abs_d = abs_w;
    end
  end

  always_comb begin
    sample_count_d = sample_count_q;
    err_count_d    = err_count_q;
    sum_abs_d      = sum_abs_q;
    max_abs_d      = max_abs_q;
    ovf_d          = ovf_q;
    if (clear) begin
      sample_count_d = '0;
      err_count_d    = '0;
      sum_abs_d      = '0;
      max_abs_d      = '0;
      ovf_d          = 1'b0;
    end else begin
      if (accept) sample_count_d = sample_count_q + 16'd1;
      if (s2_valid_q) begin
        if ((s2_err_q != 17'd0) && (err_count_q != 16'hFFFF))
          err_count_d = err_count_q + 16'd1;
        if (sum_abs_ext[ACC_W]) begin
          sum_abs_d = '1;
          ovf_d     = 1'b1;
        end else begin
          sum_abs_d = sum_abs_ext[ACC_W-1:0];
        end
        if (s2_abs_q > max_abs_q) max_abs_d = s2_abs_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      s1_valid_q     <= 1'b0;
      s1_approx_q    <= '0;
      s1_exact_q     <= '0;
      s2_valid_q     <= 1'b0;
      s2_err_q       <= '0;
      s2_abs_q       <= '0;
      sample_count_q <= '0;
      err_count_q    <= '0;
      sum_abs_q      <= '0;
      max_abs_q      <= '0;
    end else begin
      state_q        <= state_d;
      s1_valid_q     <= s1_valid_d;
      s1_approx_q    <= s1_approx_d;
      s1_exact_q     <= s1_exact_d;
      s2_valid_q     <= s2_valid_d;
      s2_err_q       <= s2_err_d;
      s2_abs_q       <= s2_abs_d;
      sample_count_q <= sample_count_d;
      err_count_q    <= err_count_d;
      sum_abs_q      <= sum_abs_d;
      max_abs_q      <= max_abs_d;
    end
  end

`ifdef ERR_SIGNED_SUM_EN
  logic [ACC_W-1:0] sum_err_q, sum_err_d;
  logic [ACC_W:0]   sum_err_ext;
  logic             serr_ovf;

  assign sum_err_ext = {sum_err_q[ACC_W-1], sum_err_q}
                     + {{(ACC_W-16){s2_err_q[16]}}, s2_err_q};
  // Signed overflow shows as the extension bit disagreeing with the MSB.
  assign serr_ovf = s2_valid_q && !clear && (sum_err_ext[ACC_W] != sum_err_ext[ACC_W-1]);

  always_comb begin
    sum_err_d = sum_err_q;
    if (clear) begin
      sum_err_d = '0;
    end else if (s2_valid_q) begin
      if (sum_err_ext[ACC_W] != sum_err_ext[ACC_W-1])
        sum_err_d = sum_err_ext[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                       : {1'b0, {(ACC_W-1){1'b1}}};
      else
        sum_err_d = sum_err_ext[ACC_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_err_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      sum_err_q <= sum_err_d;
      ovf_q     <= ovf_d | serr_ovf;
    end
  end

  assign sum_err = sum_err_q;
`else
  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign sum_err = '0;
`endif

  assign busy         = (state_q == RUN) || (state_q == DRAIN);
  assign done         = (state_q == DONE);
  assign sample_count = sample_count_q;
  assign err_count    = err_count_q;
  assign sum_abs_err  = sum_abs_q;
  assign max_abs_err  = max_abs_q;
  assign sum_overflow = ovf_q;

endmodule
`default_nettype wire
